// File: rtl/noc_pkg.sv
// noc_pkg: link-level constants and flit type shared by the PE-to-router link modules.
package noc_pkg;
    localparam int FLIT_W       = 20;
    localparam int CREDIT_DEPTH = 4;
    typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/credit_fifo.sv
// credit_fifo: ring buffer with write/read pointers and occupancy count.
// push/pop arrive already qualified by the caller; head reads 0 when empty.
module credit_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = CREDIT_DEPTH,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = !push ? wr_ptr_q : (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = !pop ? rd_ptr_q : (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        level_d  = (push && !pop) ? level_q + 1'b1 :
                   (pop && !push) ? level_q - 1'b1 : level_q;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;
endmodule

// File: rtl/credit_rx_port.sv
// credit_rx_port: receive side of the credit link; buffers flits and returns one credit per drained flit.
// Define CREDIT_RX_OVF_CHECK_EN to add the sticky err_overflow output.
module credit_rx_port
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = CREDIT_DEPTH,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] datain,
    input  logic              in_valid,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              co,
    output logic [CNT_W-1:0]  level
`ifdef CREDIT_RX_OVF_CHECK_EN
    ,
    output logic              err_overflow
`endif
);
    logic push, pop, full, empty;
    logic co_q, co_d;

    // A full buffer still accepts a flit when the head leaves in the same cycle.
    assign pop  = !empty && out_ready;
    assign push = in_valid && (!full || pop);

    credit_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk  (clk),
        .RST  (RST),
        .push (push),
        .din  (datain),
        .pop  (pop),
        .full (full),
        .empty(empty),
        .head (dataout),
        .level(level)
    );

    assign out_valid = !empty;

    always_comb co_d = pop;

    always_ff @(posedge clk) begin
        if (RST) co_q <= 1'b0;
        else     co_q <= co_d;
    end

    assign co = co_q;

`ifdef CREDIT_RX_OVF_CHECK_EN
    logic err_overflow_q, err_overflow_d;

    always_comb err_overflow_d = err_overflow_q || (in_valid && full && !pop);

    always_ff @(posedge clk) begin
        if (RST) err_overflow_q <= 1'b0;
        else     err_overflow_q <= err_overflow_d;
    end

    assign err_overflow = err_overflow_q;
`endif
endmodule
